// File: rtl/piso_sched_pkg.sv
// Shared types and constants for the PISO symbol scheduler.
package piso_sched_pkg;

  typedef enum logic [1:0] {StOff, StLoad, StShift} state_e;

  localparam logic [1:0] SrcIdle = 2'd0;
  localparam logic [1:0] SrcData = 2'd1;
  localparam logic [1:0] SrcOs   = 2'd2;
  localparam logic [1:0] SrcSkp  = 2'd3;

  localparam logic [9:0] ComSym  = 10'h17C;
  localparam logic [9:0] SkpSym  = 10'h0BC;
  localparam logic [9:0] IdleSym = 10'h0B9;

  localparam int unsigned DefSkpInterval = 1180;
  localparam int unsigned DefSkpNum      = 3;

endpackage

// File: rtl/piso_sched_skp_timer.sv
// SKP insertion timer: counts issued symbols and walks the COM/SKP sequence.
module piso_sched_skp_timer
  import piso_sched_pkg::*;
#(
  parameter int unsigned SkpInterval = DefSkpInterval,
  parameter int unsigned SkpNum      = DefSkpNum
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue,
  input  logic       take,
  output logic       skp_pending,
  output logic       skp_active,
  output logic [9:0] skp_sym
);

  localparam int unsigned CntW = $clog2(SkpInterval + 1);
  localparam int unsigned IdxW = $clog2(SkpNum + 1);

  logic [CntW-1:0] sym_cnt_q, sym_cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;

  assign skp_pending = (sym_cnt_q == CntW'(SkpInterval));
  assign skp_active  = (idx_q != '0);
  // Index 0 means the next sequence symbol is COM; 1..SkpNum are SKP fillers.
  assign skp_sym     = skp_active ? SkpSym : ComSym;

  always_comb begin
    sym_cnt_d = sym_cnt_q;
    idx_d     = idx_q;
    if (take) begin
      if (!skp_active) begin
        idx_d     = IdxW'(1);
        sym_cnt_d = '0;
      end else if (idx_q == IdxW'(SkpNum)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IdxW'(1);
      end
    end else if (issue && !skp_pending) begin
      sym_cnt_d = sym_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sym_cnt_q <= '0;
      idx_q     <= '0;
    end else begin
      sym_cnt_q <= sym_cnt_d;
      idx_q     <= idx_d;
    end
  end

endmodule

// File: rtl/piso_sched.sv
// Symbol scheduler for the 10-bit PISO: arbitrates SKP, ordered-set and data
// sources and sequences one load plus ten shift cycles per symbol.
module piso_sched
  import piso_sched_pkg::*;
#(
  parameter int unsigned SkpInterval = DefSkpInterval,
  parameter int unsigned SkpNum      = DefSkpNum
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       os_valid,
  input  logic [9:0] os_sym,
  input  logic       os_last,
  output logic       os_ready,
  input  logic       d_valid,
  input  logic [9:0] d_sym,
  output logic       d_ready,
  output logic       piso_mode,
  output logic [9:0] piso_pin,
  output logic [1:0] sym_src,
  output logic       sym_start,
  output logic       skp_pending
);

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       os_lock_q, os_lock_d;
  logic [9:0] pin_q, pin_d;
  logic [1:0] src_q, src_d;

  logic       decide, sym_issue, skp_take, skp_active;
  logic [9:0] skp_sym, sel_sym;
  logic [1:0] sel_src;

  assign decide = !rst && en &&
                  ((state_q == StOff) || (state_q == StShift && bit_cnt_q == 4'd9));

  piso_sched_skp_timer #(
    .SkpInterval(SkpInterval),
    .SkpNum     (SkpNum)
  ) u_skp_timer (
    .clk        (clk),
    .rst        (rst),
    .issue      (sym_issue),
    .take       (skp_take),
    .skp_pending(skp_pending),
    .skp_active (skp_active),
    .skp_sym    (skp_sym)
  );

  // Arbitration; an ordered set in progress outranks a pending SKP.
  always_comb begin
    os_ready  = 1'b0;
    d_ready   = 1'b0;
    sel_sym   = IdleSym;
    sel_src   = SrcIdle;
    os_lock_d = os_lock_q;
    skp_take  = 1'b0;
    sym_issue = 1'b0;
    if (decide) begin
      if (os_lock_q) begin
        sym_issue = 1'b1;
        if (os_valid) begin
          os_ready = 1'b1;
          sel_sym  = os_sym;
          sel_src  = SrcOs;
          if (os_last) os_lock_d = 1'b0;
        end
      end else if (skp_active || skp_pending) begin
        skp_take = 1'b1;
        sel_sym  = skp_sym;
        sel_src  = SrcSkp;
      end else if (os_valid) begin
        sym_issue = 1'b1;
        os_ready  = 1'b1;
        sel_sym   = os_sym;
        sel_src   = SrcOs;
        os_lock_d = !os_last;
      end else if (d_valid) begin
        sym_issue = 1'b1;
        d_ready   = 1'b1;
        sel_sym   = d_sym;
        sel_src   = SrcData;
      end else begin
        sym_issue = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    pin_d     = pin_q;
    src_d     = src_q;
    unique case (state_q)
      StOff:  if (en) state_d = StLoad;
      StLoad: begin
        state_d   = StShift;
        bit_cnt_d = 4'd0;
      end
      StShift: begin
        if (bit_cnt_q == 4'd9) begin
          state_d = en ? StLoad : StOff;
          if (!en) begin
            pin_d = IdleSym;
            src_d = SrcIdle;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      default: state_d = StOff;
    endcase
    if (decide) begin
      pin_d = sel_sym;
      src_d = sel_src;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StOff;
      bit_cnt_q <= 4'd0;
      os_lock_q <= 1'b0;
      pin_q     <= IdleSym;
      src_q     <= SrcIdle;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      os_lock_q <= os_lock_d;
      pin_q     <= pin_d;
      src_q     <= src_d;
    end
  end

  assign piso_mode = (state_q == StShift);
  assign sym_start = (state_q == StLoad);
  assign piso_pin  = pin_q;
  assign sym_src   = src_q;

endmodule

// File: tb/tb_piso_sched.sv
// Directed bench for piso_sched with a short SKP interval and a behavioural PISO.
module tb_piso_sched;

  logic       clk = 1'b0;
  logic       rst, en, os_valid, os_last, d_valid;
  logic [9:0] os_sym, d_sym;
  logic       os_ready, d_ready, piso_mode, sym_start, skp_pending;
  logic [9:0] piso_pin;
  logic [1:0] sym_src;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int dcnt  = 0;
  int ocnt  = 0;
  int scnt  = 0;
  logic [9:0] sr = 10'h0;
  logic       sout;

  always #5 clk = ~clk;

  piso_sched #(
    .SkpInterval(4),
    .SkpNum     (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .os_valid   (os_valid),
    .os_sym     (os_sym),
    .os_last    (os_last),
    .os_ready   (os_ready),
    .d_valid    (d_valid),
    .d_sym      (d_sym),
    .d_ready    (d_ready),
    .piso_mode  (piso_mode),
    .piso_pin   (piso_pin),
    .sym_src    (sym_src),
    .sym_start  (sym_start),
    .skp_pending(skp_pending)
  );

  // Behavioural PISO: load when mode=0, shift LSB first, bit9 refills.
  always @(posedge clk) begin
    sr  <= piso_mode ? {sr[9], sr[9:1]} : piso_pin;
    cyc <= cyc + 1;
  end
  assign sout = sr[0];

  always @(negedge clk) begin
    if (d_valid && d_ready) dcnt <= dcnt + 1;
    if (os_valid && os_ready) ocnt <= ocnt + 1;
    if (sym_start) scnt <= scnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_load();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (sym_start) return;
    end
    check("load_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; os_valid = 1'b0; os_last = 1'b0; d_valid = 1'b0;
    os_sym = 10'h0; d_sym = 10'h0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic slot(input string tag, input logic [9:0] pin, input logic [1:0] src);
    wait_load();
    check({tag, "_pin"}, 32'(piso_pin), 32'(pin));
    check({tag, "_src"}, 32'(sym_src), 32'(src));
  endtask

  logic [9:0] e_pin [13];
  logic [1:0] e_src [13];
  logic [9:0] bits;
  int t0, base;

  initial begin
    // Reset values
    do_reset();
    check("rst_mode", 32'(piso_mode), 32'd0);
    check("rst_pin", 32'(piso_pin), 32'h0B9);
    check("rst_src", 32'(sym_src), 32'd0);
    check("rst_start", 32'(sym_start), 32'd0);
    check("rst_pend", 32'(skp_pending), 32'd0);
    check("rst_osrdy", 32'(os_ready), 32'd0);
    check("rst_drdy", 32'(d_ready), 32'd0);

    // Idle fill and 11-cycle symbol period
    en = 1'b1;
    slot("idle1", 10'h0B9, 2'd0);
    t0 = cyc;
    slot("idle2", 10'h0B9, 2'd0);
    check("period", 32'(cyc - t0), 32'd11);
    slot("idle3", 10'h0B9, 2'd0);
    check("idle3_pend", 32'(skp_pending), 32'd0);

    // Single data symbol and its serial bit order
    do_reset();
    en = 1'b1;
    slot("d_pre", 10'h0B9, 2'd0);
    base = dcnt;
    d_valid = 1'b1; d_sym = 10'h155;
    slot("d_sym", 10'h155, 2'd1);
    d_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      bits[i] = sout;
    end
    check("serial", 32'(bits), 32'h155);
    slot("d_post", 10'h0B9, 2'd0);
    check("d_rdy_cnt", 32'(dcnt - base), 32'd1);

    // Ordered set beats data, then SKP, then data
    do_reset();
    base = dcnt;
    os_valid = 1'b1; os_sym = 10'h3C1; d_valid = 1'b1; d_sym = 10'h2AA;
    en = 1'b1;
    slot("os1", 10'h3C1, 2'd2);
    os_sym = 10'h3C2;
    slot("os2", 10'h3C2, 2'd2);
    os_sym = 10'h3C3;
    slot("os3", 10'h3C3, 2'd2);
    os_sym = 10'h3C4; os_last = 1'b1;
    slot("os4", 10'h3C4, 2'd2);
    check("os4_pend", 32'(skp_pending), 32'd1);
    os_valid = 1'b0; os_last = 1'b0;
    slot("os_com", 10'h17C, 2'd3);
    slot("os_skp1", 10'h0BC, 2'd3);
    slot("os_skp2", 10'h0BC, 2'd3);
    slot("os_skp3", 10'h0BC, 2'd3);
    check("os_d_quiet", 32'(dcnt - base), 32'd0);
    slot("os_data", 10'h2AA, 2'd1);
    check("os_d_once", 32'(dcnt - base), 32'd1);

    // Periodic SKP with data always valid
    do_reset();
    e_pin = '{10'h2AA, 10'h2AA, 10'h2AA, 10'h2AA, 10'h17C, 10'h0BC, 10'h0BC,
              10'h0BC, 10'h2AA, 10'h2AA, 10'h2AA, 10'h2AA, 10'h17C};
    e_src = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1, 2'd1, 2'd1, 2'd1, 2'd3};
    base = dcnt;
    d_valid = 1'b1; d_sym = 10'h2AA;
    en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      slot($sformatf("skp%0d", i), e_pin[i], e_src[i]);
      if (i == 3) check("skp_pend_up", 32'(skp_pending), 32'd1);
      if (i == 4) check("skp_pend_clr", 32'(skp_pending), 32'd0);
    end
    check("skp_d_cnt", 32'(dcnt - base), 32'd8);
    d_valid = 1'b0;

    // SKP held off by a locked ordered set with a valid gap
    do_reset();
    base = ocnt;
    os_valid = 1'b1; os_sym = 10'h0F1;
    en = 1'b1;
    slot("lk1", 10'h0F1, 2'd2);
    os_sym = 10'h0F2;
    slot("lk2", 10'h0F2, 2'd2);
    os_valid = 1'b0;
    slot("lk_gap", 10'h0B9, 2'd0);
    os_valid = 1'b1; os_sym = 10'h0F3;
    slot("lk3", 10'h0F3, 2'd2);
    check("lk3_pend", 32'(skp_pending), 32'd1);
    os_sym = 10'h0F4; os_last = 1'b1;
    slot("lk4", 10'h0F4, 2'd2);
    check("lk4_pend", 32'(skp_pending), 32'd1);
    os_valid = 1'b0; os_last = 1'b0;
    check("lk_os_cnt", 32'(ocnt - base), 32'd4);
    slot("lk_com", 10'h17C, 2'd3);
    check("lk_com_pend", 32'(skp_pending), 32'd0);
    slot("lk_skp", 10'h0BC, 2'd3);

    // en dropped mid-symbol: symbol completes, then OFF
    do_reset();
    en = 1'b1;
    slot("en_sym", 10'h0B9, 2'd0);
    repeat (4) tick();
    en = 1'b0;
    repeat (6) tick();
    check("en_bit9_mode", 32'(piso_mode), 32'd1);
    tick();
    check("en_off_mode", 32'(piso_mode), 32'd0);
    check("en_off_start", 32'(sym_start), 32'd0);
    base = scnt;
    repeat (20) tick();
    check("en_off_quiet", 32'(scnt - base), 32'd0);

    // rst mid-symbol
    d_valid = 1'b1; d_sym = 10'h155;
    en = 1'b1;
    slot("rs_sym", 10'h155, 2'd1);
    d_valid = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    check("rs_mode", 32'(piso_mode), 32'd0);
    check("rs_pin", 32'(piso_pin), 32'h0B9);
    check("rs_src", 32'(sym_src), 32'd0);
    check("rs_start", 32'(sym_start), 32'd0);
    check("rs_drdy", 32'(d_ready), 32'd0);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_sched.md
# piso_sched

Symbol scheduler and sequencer for the 10-bit PCIe transmit PISO serializer. Each symbol slot it arbitrates among a SKP-insertion timer, an ordered-set source and a data source, with idle fill when nothing is pending. It drives the serializer's load/shift control and parallel word, giving 11 clock cycles per symbol (1 load, 10 shift, LSB first). It sits between the 8b/10b encoder outputs and the PISO.

## Interface
- COM_SYM, 10'h17C: K28.5 (RD-), bit0 = a; first symbol of SKP ordered set
- SKP_SYM, 10'h0BC: K28.0 (RD-); SKP filler symbol
- IDLE_SYM, 10'h0B9: fill symbol when no source is valid
- SKP_INTERVAL, 1180: symbols between SKP ordered sets (min 2)
- SKP_NUM, 3: SKP_SYM count after COM_SYM (1..7)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- en  in  1  transmit enable
- os_valid  in  1  ordered-set symbol available
- os_sym  in  10  ordered-set symbol
- os_last  in  1  qualifies os_sym as the final symbol of its ordered set
- os_ready  out  1  os transfer strobe
- d_valid  in  1  data symbol available
- d_sym  in  10  data symbol
- d_ready  out  1  data transfer strobe
- piso_mode  out  1  0 = load, 1 = shift (to PISO mode)
- piso_pin  out  10  parallel word (to PISO pin)
- sym_src  out  2  source of piso_pin: 0 idle, 1 data, 2 os, 3 skp/com
- sym_start  out  1  high during the load cycle
- skp_pending  out  1  SKP insertion owed

## Operation
- States: OFF, LOAD, SHIFT. bit_cnt runs 0..9 in SHIFT.
- OFF: piso_mode=0, piso_pin=IDLE_SYM, sym_src=0. With en=1 it is a decision cycle, then goes to LOAD.
- LOAD: piso_mode=0 and sym_start=1 for exactly one cycle; the PISO captures piso_pin. Next state is SHIFT with bit_cnt=0.
- SHIFT: piso_mode=1 for 10 cycles. bit_cnt==9 is a decision cycle.
  - en=1: next state is LOAD.
  - en=0: next state is OFF.
  - A symbol in flight always completes; deasserting en never truncates it.
- Decision priority, first match wins:
  1. os_lock set: os symbol if os_valid, else IDLE_SYM; lock is held.
  2. SKP sequence active, or skp_pending: next of COM_SYM, SKP_SYM×SKP_NUM.
  3. os_valid: os symbol. Sets os_lock unless os_last.
  4. d_valid: data symbol.
  5. IDLE_SYM.
- Handshake rules:
  - os_ready/d_ready are combinational and high only in a decision cycle where that source wins (rule 1 with os_valid, rule 3, or rule 4). A transfer is valid && ready.
  - Sources must hold valid and sym until transferred.
  - Accepting an os symbol with os_last=1 clears os_lock.
- SKP timer:
  - sym_cnt counts every symbol issued outside a SKP sequence.
  - When sym_cnt reaches SKP_INTERVAL, skp_pending=1 and sym_cnt holds.
  - Starting the SKP sequence (issuing COM_SYM) clears skp_pending and sym_cnt.
  - Data may be interrupted at any symbol boundary. An ordered set is never interrupted; SKP waits for os_last.
- sym_cnt and the timer freeze in OFF.

## Timing
- Reset values: piso_mode=0, piso_pin=IDLE_SYM, sym_src=0, sym_start=0, skp_pending=0, os_ready=d_ready=0. Internal: state=OFF, bit_cnt=0, sym_cnt=0, os_lock=0, SKP sequence index=0.
- rst mid-symbol: OFF on the next edge; the partial symbol and any SKP sequence are abandoned.
- piso_mode, piso_pin and sym_src are registered and update on the edge ending a decision cycle.
- Symbol period is 11 cycles. PISO sout carries bits 0..9 on the 10 cycles following the LOAD edge, then repeats bit9 for the next load cycle.
- Latency: en rising in OFF → LOAD on the next cycle → first serial bit 2 cycles later.
- If a source asserts valid in a non-decision cycle, it waits for the next decision cycle.
- os_valid low while os_lock is set: IDLE_SYM is inserted, no os_ready, lock retained.
- skp_pending rising in the same cycle as a decision: takes effect in that decision unless os_lock is set.

## Structure
- Package piso_sched_pkg holds:
  - state enum (OFF, LOAD, SHIFT);
  - sym_src encodings;
  - default COM/SKP/IDLE symbol constants.
- Sub-module piso_sched_skp_timer contains sym_cnt, skp_pending and the SKP sequence index.
- Arbitration and the FSM stay in piso_sched. The PISO is instantiated alongside it by the parent.

## Test plan
- Reset, then en=1 with no valid inputs → piso_pin=0x0B9 and sym_src=0 every slot; sym_start period of exactly 11 cycles.
- d_valid with d_sym=0x155 held → one d_ready pulse at bit_cnt==9. Next LOAD has piso_pin=0x155, sym_src=1; PISO sout serial order 1,0,1,0,1,0,1,0,1,0.
- os_valid and d_valid both high, 4-symbol ordered set (os_last on the 4th) → 4 consecutive os slots, then data; d_ready stays low during the set.
- SKP_INTERVAL=4, SKP_NUM=3, d_valid always high → after every 4 data symbols, slots are 0x17C then 0x0BC×3 with sym_src=3; skp_pending rises and then clears on the COM slot.
- skp_pending raised during a locked ordered set → SKP slots appear only after the os_last symbol. An os_valid gap inside the set produces one IDLE_SYM slot with the lock kept.
- en dropped at bit_cnt=3 → the symbol finishes, then OFF. rst asserted at bit_cnt=5 → all outputs at reset values on the next edge.
